// File: rtl/alu_pkg.sv
// Opcodes, FSM states and opcode-class helpers shared by the alu_mdu execution unit.
package alu_pkg;

  localparam logic [4:0] OP_AND   = 5'b00000;
  localparam logic [4:0] OP_OR    = 5'b00001;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_XOR   = 5'b00011;
  localparam logic [4:0] OP_NOR   = 5'b00100;
  localparam logic [4:0] OP_SRL   = 5'b00101;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_SLT   = 5'b00111;
  localparam logic [4:0] OP_SLL   = 5'b01000;
  localparam logic [4:0] OP_ADDU  = 5'b01001;
  localparam logic [4:0] OP_SUBU  = 5'b01010;
  localparam logic [4:0] OP_SLTU  = 5'b01011;
  localparam logic [4:0] OP_SRA   = 5'b01110;
  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  function automatic logic is_mul(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative one-bit-per-cycle multiply (shift-add) and divide (restoring) engine.
// The divider datapath exists only when ALU_MDU_DIV_EN is defined.
module alu_md_iter import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int CNT_W = $clog2(WIDTH);

  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   acc_q, acc_d, sh_q, sh_d, d_q;
  logic               neg_lo_q;
  logic               sgn, is_d;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
`ifdef ALU_MDU_DIV_EN
  logic               div_q, neg_hi_q;
  logic [WIDTH:0]     rem_sh, diff;
  assign is_d = is_div(op);
`else
  assign is_d = 1'b0;
`endif

  assign sgn   = (op == OP_MULT) || (op == OP_DIV);
  assign mag_a = (sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b = (sgn && b[WIDTH-1]) ? -b : b;
  // Final step's result is presented combinationally so the top can register it on that edge.
  assign done  = busy_q && (cnt_q == '0);

  always_comb begin
    sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, d_q} : '0);
    acc_d = sum[WIDTH:1];
    sh_d  = {sum[0], sh_q[WIDTH-1:1]};
`ifdef ALU_MDU_DIV_EN
    rem_sh = {acc_q, sh_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, d_q};
    if (div_q) begin
      acc_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      sh_d  = {sh_q[WIDTH-2:0], ~diff[WIDTH]};
    end
`endif
    prod = {acc_d, sh_d};
    if (neg_lo_q) prod = -prod;
    {hi, lo} = prod;
`ifdef ALU_MDU_DIV_EN
    if (div_q) begin
      lo = neg_lo_q ? -sh_d : sh_d;
      hi = neg_hi_q ? -acc_d : acc_d;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      d_q      <= '0;
      neg_lo_q <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      div_q    <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= CNT_W'(WIDTH - 1);
      acc_q    <= '0;
      sh_q     <= is_d ? mag_a : mag_b;
      d_q      <= is_d ? mag_b : mag_a;
      // Divide-by-zero keeps the all-ones quotient unsigned.
      neg_lo_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]) && !(is_d && (b == '0));
`ifdef ALU_MDU_DIV_EN
      div_q    <= is_d;
      neg_hi_q <= sgn && a[WIDTH-1];
`endif
    end else if (busy_q) begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Handshaked EX-stage ALU with iterative multiply/divide; divider built only
// when ALU_MDU_DIV_EN is defined, otherwise DIV/DIVU flag overflow in one cycle.
module alu_mdu import alu_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   res,
  output logic [WIDTH-1:0]   hi,
  output logic               zero,
  output logic               overflow
);
  state_t           state;
  logic             accept, md_op, md_done;
  logic [WIDTH-1:0] sum, dif, alu_res, md_lo, md_hi;
  logic             alu_ovf;

  assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
`ifdef ALU_MDU_DIV_EN
  assign md_op    = is_mul(op) || is_div(op);
`else
  assign md_op    = is_mul(op);
`endif
  assign sum = a + b;
  assign dif = a - b;

  always_comb begin
    alu_res = sum;
    alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SUB: begin
        alu_res = dif;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  begin alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)}; alu_ovf = 1'b0; end
      OP_SLTU: begin alu_res = {{(WIDTH-1){1'b0}}, a < b}; alu_ovf = 1'b0; end
      OP_SRL:  alu_res = b >> shamt;
      OP_SLL:  alu_res = b << shamt;
      OP_SRA:  alu_res = $signed(b) >>> shamt;
      OP_ADDU: alu_ovf = 1'b0;
      OP_SUBU: begin alu_res = dif; alu_ovf = 1'b0; end
`ifndef ALU_MDU_DIV_EN
      OP_DIV, OP_DIVU: begin alu_res = '0; alu_ovf = 1'b1; end
`endif
      default: ;
    endcase
    if (op inside {OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRL, OP_SLL, OP_SRA}) alu_ovf = 1'b0;
  end

  alu_md_iter #(.WIDTH(WIDTH)) u_md (
    .clk   (clk),
    .rst   (rst),
    .start (accept && md_op),
    .op    (op),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      res       <= '0;
      hi        <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
    end else if (state == S_BUSY) begin
      if (md_done) begin
        state     <= S_DONE;
        out_valid <= 1'b1;
        res       <= md_lo;
        hi        <= md_hi;
        zero      <= (md_lo == '0);
        overflow  <= 1'b0;
      end
    end else if (accept) begin
      if (md_op) begin
        state     <= S_BUSY;
        out_valid <= 1'b0;
      end else begin
        state     <= S_DONE;
        out_valid <= 1'b1;
        res       <= alu_res;
        hi        <= '0;
        zero      <= (alu_res == '0);
        overflow  <= alu_ovf;
      end
    end else if ((state == S_DONE) && out_ready) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed vector table, randomized ops against
// an arithmetic reference model, backpressure and mid-operation reset sequences.
module tb_alu_mdu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res, hi;
  logic        zero, overflow;

  int n_tests = 0;
  int n_fail  = 0;

  alu_mdu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .hi        (hi),
    .zero      (zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

`ifdef ALU_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [31:0] r, h;
    logic        ovf;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: results straight from the arithmetic definitions.
  task automatic model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] s, output logic [31:0] r, output logic [31:0] h,
                       output logic ovf, output int lat);
    longint sx, sy, t;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    h = 0; ovf = 0; lat = 1;
    case (o)
      5'b00000: r = x & y;
      5'b00001: r = x | y;
      5'b00011: r = x ^ y;
      5'b00100: r = ~(x | y);
      5'b00110: begin t = sx - sy; r = t[31:0]; ovf = (t != longint'($signed(t[31:0]))); end
      5'b00111: r = (sx < sy) ? 32'd1 : 32'd0;
      5'b01011: r = (x < y) ? 32'd1 : 32'd0;
      5'b00101: r = x >> 0 == 0 ? (y >> s) : (y >> s);
      5'b01000: r = y << s;
      5'b01110: r = 32'($signed(y) >>> s);
      5'b01001: r = x + y;
      5'b01010: r = x - y;
      5'b10000: begin p = 64'(sx * sy); r = p[31:0]; h = p[63:32]; lat = 33; end
      5'b10001: begin p = {32'd0, x} * {32'd0, y}; r = p[31:0]; h = p[63:32]; lat = 33; end
      5'b10010, 5'b10011: begin
        if (!DIV_EN) begin r = 0; h = 0; ovf = 1; end
        else begin
          lat = 33;
          if (y == 0) begin r = '1; h = x; end
          else if (o == 5'b10010) begin t = sx / sy; r = t[31:0]; t = sx % sy; h = t[31:0]; end
          else begin r = x / y; h = x % y; end
        end
      end
      default: begin t = sx + sy; r = t[31:0]; ovf = (t != longint'($signed(t[31:0]))); end
    endcase
  endtask

  // Issue one op with out_ready=1 and check result, flags and latency.
  task automatic run_op(input int id, input logic [4:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] s, input logic [31:0] er,
                        input logic [31:0] eh, input logic eovf, input int elat);
    int n;
    string tag;
    tag = $sformatf("op%0d(%b)", id, o);
    out_ready = 1; in_valid = 1; op = o; a = x; b = y; shamt = s;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 0; a = ~x; b = ~y;
    n = 1;
    while (!out_valid && n < 100) begin tick(); n++; end
    check({tag, " latency"}, 64'(n), 64'(elat));
    check({tag, " res"}, 64'(res), 64'(er));
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " zero"}, 64'(zero), 64'(er == 0));
    check({tag, " ovf"}, 64'(overflow), 64'(eovf));
    tick();
  endtask

  vec_t vecs[$];

  initial begin
    logic [4:0] ops[17] = '{5'b00000, 5'b00001, 5'b00010, 5'b00110, 5'b00100, 5'b00111,
                            5'b00011, 5'b00101, 5'b01000, 5'b01110, 5'b01001, 5'b01010,
                            5'b01011, 5'b10000, 5'b10001, 5'b10010, 5'b10011};
    logic [31:0] r, h, x, y;
    logic        v;
    int          l, n;
    logic [4:0]  o, s;

    vecs.push_back('{5'b00010, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000, 32'd0, 1'b1, 1});
    vecs.push_back('{5'b01110, 32'd0, 32'h80000000, 5'd4, 32'hF8000000, 32'd0, 1'b0, 1});
    vecs.push_back('{5'b00101, 32'd0, 32'h80000000, 5'd4, 32'h08000000, 32'd0, 1'b0, 1});
    vecs.push_back('{5'b10000, 32'hFFFFFFFE, 32'd3, 5'd0, 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0, 33});
    vecs.push_back('{5'b10001, 32'hFFFFFFFE, 32'd3, 5'd0, 32'hFFFFFFFA, 32'h00000002, 1'b0, 33});
    vecs.push_back('{5'b00000, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000F000, 32'd0, 1'b0, 1});
    vecs.push_back('{5'b00110, 32'h80000000, 32'd1, 5'd0, 32'h7FFFFFFF, 32'd0, 1'b1, 1});
    vecs.push_back('{5'b00111, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 32'd0, 1'b0, 1});
    vecs.push_back('{5'b01011, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 32'd0, 1'b0, 1});
    vecs.push_back('{5'b11111, 32'd2, 32'd3, 5'd0, 32'd5, 32'd0, 1'b0, 1});
    vecs.push_back('{5'b01000, 32'd0, 32'd1, 5'd31, 32'h80000000, 32'd0, 1'b0, 1});
    vecs.push_back('{5'b00100, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFF, 32'd0, 1'b0, 1});
    vecs.push_back('{5'b01001, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000, 32'd0, 1'b0, 1});
    vecs.push_back('{5'b01010, 32'd0, 32'd1, 5'd0, 32'hFFFFFFFF, 32'd0, 1'b0, 1});
    if (DIV_EN) begin
      vecs.push_back('{5'b10010, -32'sd7, 32'd2, 5'd0, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33});
      vecs.push_back('{5'b10010, 32'd7, -32'sd2, 5'd0, 32'hFFFFFFFD, 32'd1, 1'b0, 33});
      vecs.push_back('{5'b10011, 32'd5, 32'd0, 5'd0, 32'hFFFFFFFF, 32'd5, 1'b0, 33});
      vecs.push_back('{5'b10010, -32'sd9, 32'd0, 5'd0, 32'hFFFFFFFF, -32'sd9, 1'b0, 33});
      vecs.push_back('{5'b10010, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h80000000, 32'd0, 1'b0, 33});
    end else begin
      vecs.push_back('{5'b10010, -32'sd7, 32'd2, 5'd0, 32'd0, 32'd0, 1'b1, 1});
      vecs.push_back('{5'b10011, 32'd5, 32'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1});
    end

    // Reset state
    tick(); tick();
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst res", 64'(res), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst zero", 64'(zero), 64'd1);
    check("rst ovf", 64'(overflow), 64'd0);
    rst = 0;
    tick();

    foreach (vecs[i])
      run_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh,
             vecs[i].r, vecs[i].h, vecs[i].ovf, vecs[i].lat);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      o = (i % 8 == 7) ? 5'($urandom) : ops[$urandom_range(16, 0)];
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(9, 0)) : $urandom;
      if (i % 5 == 0) y = -y;
      s = 5'($urandom);
      model(o, x, y, s, r, h, v, l);
      run_op(100 + i, o, x, y, s, r, h, v, l);
    end

    // Backpressure: SUB result held while out_ready=0
    out_ready = 0; in_valid = 1; op = 5'b00110; a = 32'd10; b = 32'd3;
    tick();
    in_valid = 0;
    check("bp valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom;
      tick();
      check("bp res stable", 64'(res), 64'd7);
      check("bp in_ready low", 64'(in_ready), 64'd0);
    end
    in_valid = 1; op = 5'b00000; a = 32'h0000F0F0; b = 32'h0000FF00; out_ready = 1;
    #1;
    check("bp in_ready on release", 64'(in_ready), 64'd1);
    tick();
    in_valid = 0;
    check("b2b valid", 64'(out_valid), 64'd1);
    check("b2b res", 64'(res), 64'h0000F000);
    tick();

    // Reset during a MULT
    in_valid = 1; op = 5'b10000; a = 32'd12345; b = 32'd678;
    tick();
    in_valid = 0;
    repeat (9) tick();
    rst = 1;
    #1;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    check("midrst res", 64'(res), 64'd0);
    tick();
    rst = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) n++;
    end
    check("midrst no result", 64'(n), 64'd0);
    run_op(200, 5'b00000, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000F000, 32'd0, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
